// File: rtl/calc_result_display.sv
// Latches a sign-magnitude result and shows it on a 4-digit, active-low, multiplexed 7-seg display.
// A new value reaches the display only at frame boundaries. Optional macro: CALC_DISP_LZS_EN (blank a zero tens digit).
module calc_result_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       sign_in,
   input  logic [3:0] mag_in,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       pending,
   output logic       frame
);
   localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);
   localparam logic [6:0]  SEG_MINUS = 7'b0111111;
   localparam logic [6:0]  SEG_BLANK = 7'b1111111;

   logic [15:0] presc_q, presc_d;
   logic [1:0]  idx_q, idx_d;
   logic [4:0]  shadow_q, shadow_d;   // {sign, mag}
   logic [4:0]  disp_q, disp_d;
   logic        pending_q, pending_d;
   logic        frame_q, frame_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        wrap, boundary;
   logic [3:0]  mag, ones;
   logic        tens;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   always_comb begin
      wrap     = (presc_q == PRESC_MAX);
      boundary = wrap && (idx_q == 2'd3);
      presc_d  = wrap ? 16'd0 : presc_q + 16'd1;
      idx_d    = wrap ? idx_q + 2'd1 : idx_q;
      shadow_d = load ? {sign_in, mag_in} : shadow_q;
      frame_d  = boundary && pending_q;
      // The display takes the pre-load shadow, so a load on the boundary waits a full frame.
      disp_d    = frame_d ? shadow_q : disp_q;
      pending_d = load || (pending_q && !frame_d);
   end

   always_comb begin
      mag  = disp_q[3:0];
      tens = (mag >= 4'd10);
      ones = tens ? mag - 4'd10 : mag;
      an_d = ~(4'b0001 << idx_q);
      case (idx_q)
         2'd0: seg_d = seg7(ones);
`ifdef CALC_DISP_LZS_EN
         2'd1: seg_d = tens ? seg7(4'd1) : SEG_BLANK;
`else
         2'd1: seg_d = seg7({3'b000, tens});
`endif
         // Negative zero shows no minus.
         2'd2: seg_d = (disp_q[4] && (mag != 4'd0)) ? SEG_MINUS : SEG_BLANK;
         default: seg_d = SEG_BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= 16'd0;
         idx_q     <= 2'd0;
         shadow_q  <= 5'd0;
         disp_q    <= 5'd0;
         pending_q <= 1'b0;
         frame_q   <= 1'b0;
         an_q      <= 4'b1111;
         seg_q     <= SEG_BLANK;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         frame_q   <= frame_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign an      = an_q;
   assign seg     = seg_q;
   assign pending = pending_q;
   assign frame   = frame_q;
endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display with REFRESH_DIV=4; expected segment patterns are hand-coded.
module tb_calc_result_display;
   localparam logic [6:0] S0    = 7'b1000000;
   localparam logic [6:0] S1    = 7'b1111001;
   localparam logic [6:0] S2    = 7'b0100100;
   localparam logic [6:0] S3    = 7'b0110000;
   localparam logic [6:0] S5    = 7'b0010010;
   localparam logic [6:0] S7    = 7'b1111000;
   localparam logic [6:0] MINUS = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;
`ifdef CALC_DISP_LZS_EN
   localparam logic [6:0] TENS0 = BLANK;
`else
   localparam logic [6:0] TENS0 = S0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic       sign_in = 1'b0;
   logic [3:0] mag_in = 4'd0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       pending;
   logic       frame;

   int n_cmp = 0;
   int n_err = 0;

   calc_result_display #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .sign_in(sign_in), .mag_in(mag_in),
      .an(an), .seg(seg), .pending(pending), .frame(frame)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic s, input logic [3:0] m);
      load = 1'b1; sign_in = s; mag_in = m;
      step();
      load = 1'b0;
   endtask

   // Outputs after a fresh reset release: idx0 shows exp0, idx1 the zero tens digit, rest blank.
   task automatic idle_check(input string name, input int n, input logic [6:0] exp0);
      for (int j = 0; j < n; j++) begin
         int i;
         logic [3:0] ean;
         logic [6:0] eseg;
         step();
         i = (j / 4) % 4;
         ean = ~(4'b0001 << i);
         eseg = (i == 0) ? exp0 : ((i == 1) ? TENS0 : BLANK);
         n_cmp++;
         if (an !== ean) begin n_err++; $display("FAIL %s an j=%0d: got %b expected %b", name, j, an, ean); end
         n_cmp++;
         if (seg !== eseg) begin n_err++; $display("FAIL %s seg j=%0d: got %b expected %b", name, j, seg, eseg); end
         n_cmp++;
         if (pending !== 1'b0) begin n_err++; $display("FAIL %s pending j=%0d: got %b expected 0", name, j, pending); end
         n_cmp++;
         if (frame !== 1'b0) begin n_err++; $display("FAIL %s frame j=%0d: got %b expected 0", name, j, frame); end
      end
   endtask

   task automatic wait_frame(input string name, input logic exp_pend);
      int k = 0;
      while (frame !== 1'b1 && k < 40) begin
         n_cmp++;
         if (pending !== 1'b1) begin n_err++; $display("FAIL %s pending-wait k=%0d: got %b expected 1", name, k, pending); end
         step();
         k++;
      end
      n_cmp++;
      if (frame !== 1'b1) begin
         n_err++; $display("FAIL %s frame-timeout: got %b expected 1 within 40 cycles", name, frame);
      end else begin
         n_cmp++;
         if (pending !== exp_pend) begin n_err++; $display("FAIL %s pending-at-frame: got %b expected %b", name, pending, exp_pend); end
      end
   endtask

   // Called on the frame-pulse sample; checks the 16 digit slots that follow.
   task automatic check_frame(input string name, input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
      logic [6:0] exp_d [4];
      exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = BLANK;
      for (int s = 0; s < 16; s++) begin
         int i;
         logic [3:0] ean;
         step();
         i = s / 4;
         ean = ~(4'b0001 << i);
         n_cmp++;
         if (an !== ean) begin n_err++; $display("FAIL %s an s=%0d: got %b expected %b", name, s, an, ean); end
         n_cmp++;
         if (seg !== exp_d[i]) begin n_err++; $display("FAIL %s seg s=%0d: got %b expected %b", name, s, seg, exp_d[i]); end
         if (s < 15) begin
            n_cmp++;
            if (frame !== 1'b0) begin n_err++; $display("FAIL %s frame s=%0d: got %b expected 0", name, s, frame); end
         end
      end
   endtask

   task automatic check_reset_vals(input string name);
      n_cmp++;
      if (an !== 4'b1111) begin n_err++; $display("FAIL %s an: got %b expected 1111", name, an); end
      n_cmp++;
      if (seg !== BLANK) begin n_err++; $display("FAIL %s seg: got %b expected %b", name, seg, BLANK); end
      n_cmp++;
      if (pending !== 1'b0) begin n_err++; $display("FAIL %s pending: got %b expected 0", name, pending); end
      n_cmp++;
      if (frame !== 1'b0) begin n_err++; $display("FAIL %s frame: got %b expected 0", name, frame); end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step(); step(); step();
      check_reset_vals("reset");
      rst_n = 1'b1;
      idle_check("idle", 32, S0);
   endtask

   task automatic test_pos5;
      do_load(1'b0, 4'd5);
      wait_frame("pos5", 1'b0);
      check_frame("pos5", S5, TENS0, BLANK);
   endtask

   task automatic test_neg12;
      do_load(1'b1, 4'd12);
      wait_frame("neg12", 1'b0);
      check_frame("neg12", S2, S1, MINUS);
   endtask

   task automatic test_neg_zero;
      do_load(1'b1, 4'd0);
      wait_frame("negzero", 1'b0);
      check_frame("negzero", S0, TENS0, BLANK);
   endtask

   task automatic test_back_to_back;
      do_load(1'b0, 4'd1);
      do_load(1'b0, 4'd8);
      do_load(1'b1, 4'd15);
      wait_frame("b2b", 1'b0);
      check_frame("b2b", S5, S1, MINUS);
   endtask

   // Entered at frame slot 0; the load of -7 lands on slot 15, the boundary cycle.
   task automatic test_boundary_load;
      step(); step();
      do_load(1'b0, 4'd3);
      n_cmp++;
      if (pending !== 1'b1) begin n_err++; $display("FAIL bnd pending-after-load: got %b expected 1", pending); end
      for (int k = 0; k < 12; k++) step();
      do_load(1'b1, 4'd7);
      n_cmp++;
      if (frame !== 1'b1) begin n_err++; $display("FAIL bnd frame-on-boundary: got %b expected 1", frame); end
      n_cmp++;
      if (pending !== 1'b1) begin n_err++; $display("FAIL bnd pending-held: got %b expected 1", pending); end
      check_frame("bnd-first", S3, TENS0, BLANK);
      wait_frame("bnd-second", 1'b0);
      check_frame("bnd-second", S7, TENS0, MINUS);
   endtask

   task automatic test_reset_mid;
      do_load(1'b0, 4'd9);
      step(); step();
      rst_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      step();
      rst_n = 1'b1;
      idle_check("after-reset", 40, S0);
   endtask

   initial begin
      test_reset();
      test_pos5();
      test_neg12();
      test_neg_zero();
      test_back_to_back();
      test_boundary_load();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
